alu_issue_stage: RTL and testbench

Upstream issue stage for the 16-bit ALU. It accepts decoded instructions with a valid/ready handshake and maps the 4-bit opcode to the ALU's 3-bit control. It selects and extends operands, registers them, and drives the ALU inputs. The ALU registers its result every clock with no enable, so this block also tracks which ALU result is valid and which register it is for. Under downstream backpressure it holds the ALU result stable by replaying the in-flight operands.

---
 rtl/alu_issue_stage_if.sv | 31 +++
 rtl/alu_issue_stage.sv | 112 +++++++++++
 tb/tb_alu_issue_stage.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - instruction, ALU drive and result-tracking signals of the ALU issue stage
interface alu_issue_stage_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3,
    parameter int IMM_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_rs_val;
    logic [WIDTH-1:0] in_rt_val;
    logic [IMM_W-1:0] in_imm;
    logic [TAG_W-1:0] in_dest;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [2:0]       alu_control;
    logic             res_valid;
    logic             res_ready;
    logic [TAG_W-1:0] res_dest;
    logic             illegal_op;

    modport master (
        output in_valid, in_op, in_rs_val, in_rt_val, in_imm, in_dest, res_ready,
        input  in_ready, alu_in1, alu_in2, alu_control, res_valid, res_dest, illegal_op
    );

    modport slave (
        input  in_valid, in_op, in_rs_val, in_rt_val, in_imm, in_dest, res_ready,
        output in_ready, alu_in1, alu_in2, alu_control, res_valid, res_dest, illegal_op
    );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decodes and issues operands to the free-running ALU and tracks its result
module alu_issue_stage #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3,
    parameter int IMM_W = 8
) (
    input logic             clock,
    input logic             reset,
    alu_issue_stage_if.slave bus
);
    localparam logic [2:0] CTL_AND = 3'd0;
    localparam logic [2:0] CTL_OR  = 3'd1;
    localparam logic [2:0] CTL_ADD = 3'd2;
    localparam logic [2:0] CTL_SLL = 3'd4;
    localparam logic [2:0] CTL_SRL = 3'd5;
    localparam logic [2:0] CTL_SRA = 3'd6;
    localparam logic [2:0] CTL_SLT = 3'd7;

    logic             stall;
    logic             accept;
    logic             dec_legal;
    logic [2:0]       dec_ctrl;
    logic [WIDTH-1:0] dec_in2;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_zext;
    logic [WIDTH-1:0] shamt_zext;

    logic             issue_valid;
    logic [WIDTH-1:0] issue_in1;
    logic [WIDTH-1:0] issue_in2;
    logic [2:0]       issue_ctrl;
    logic [TAG_W-1:0] issue_dest;

    logic [WIDTH-1:0] shadow_in1;
    logic [WIDTH-1:0] shadow_in2;
    logic [2:0]       shadow_ctrl;

    logic             res_valid_q;
    logic [TAG_W-1:0] res_dest_q;
    logic             illegal_q;

    assign stall  = res_valid_q & ~bus.res_ready;
    assign accept = bus.in_valid & ~stall;

    assign imm_sext   = {{(WIDTH-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};
    assign imm_zext   = {{(WIDTH-IMM_W){1'b0}}, bus.in_imm};
    assign shamt_zext = {{(WIDTH-4){1'b0}}, bus.in_imm[3:0]};

    // Register ops pass op[2:0] straight through; immediate ops remap onto the same ALU functions.
    always_comb begin
        dec_legal = 1'b1;
        dec_ctrl  = bus.in_op[2:0];
        dec_in2   = bus.in_rt_val;
        if (bus.in_op[3]) begin
            case (bus.in_op[2:0])
                3'd0: begin dec_ctrl = CTL_ADD; dec_in2 = imm_sext;   end
                3'd1: begin dec_ctrl = CTL_AND; dec_in2 = imm_zext;   end
                3'd2: begin dec_ctrl = CTL_OR;  dec_in2 = imm_zext;   end
                3'd3: begin dec_ctrl = CTL_SLT; dec_in2 = imm_sext;   end
                3'd4: begin dec_ctrl = CTL_SLL; dec_in2 = shamt_zext; end
                3'd5: begin dec_ctrl = CTL_SRL; dec_in2 = shamt_zext; end
                3'd6: begin dec_ctrl = CTL_SRA; dec_in2 = shamt_zext; end
                default: begin
                    dec_legal = 1'b0;
                    dec_ctrl  = CTL_AND;
                    dec_in2   = bus.in_rt_val;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_valid <= 1'b0;
            issue_in1   <= '0;
            issue_in2   <= '0;
            issue_ctrl  <= '0;
            issue_dest  <= '0;
            shadow_in1  <= '0;
            shadow_in2  <= '0;
            shadow_ctrl <= '0;
            res_valid_q <= 1'b0;
            res_dest_q  <= '0;
            illegal_q   <= 1'b0;
        end else begin
            illegal_q <= accept & ~dec_legal;
            if (!stall) begin
                issue_valid <= accept & dec_legal;
                if (accept && dec_legal) begin
                    issue_in1  <= bus.in_rs_val;
                    issue_in2  <= dec_in2;
                    issue_ctrl <= dec_ctrl;
                    issue_dest <= bus.in_dest;
                end
                // The ALU samples the issue set on this same edge; keep a copy to replay while stalled.
                shadow_in1  <= issue_in1;
                shadow_in2  <= issue_in2;
                shadow_ctrl <= issue_ctrl;
                res_valid_q <= issue_valid;
                res_dest_q  <= issue_dest;
            end
        end
    end

    assign bus.in_ready    = ~stall;
    assign bus.alu_in1     = stall ? shadow_in1  : issue_in1;
    assign bus.alu_in2     = stall ? shadow_in2  : issue_in2;
    assign bus.alu_control = stall ? shadow_ctrl : issue_ctrl;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_dest    = res_dest_q;
    assign bus.illegal_op  = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with a registered ALU model
module tb_alu_issue_stage;
    logic clock;
    logic reset;

    alu_issue_stage_if #(.WIDTH(16), .TAG_W(3), .IMM_W(8)) bus ();

    alu_issue_stage #(.WIDTH(16), .TAG_W(3), .IMM_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] res;
        logic [2:0]  dest;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   ill_flag   = 0;
    bit   rr_rand    = 0;
    bit   rr_force   = 1;
    logic [15:0] alu_result;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Downstream ALU: registers its result every clock, no enable, no reset.
    always @(posedge clock) begin
        case (bus.alu_control)
            3'd0: alu_result <= bus.alu_in1 & bus.alu_in2;
            3'd1: alu_result <= bus.alu_in1 | bus.alu_in2;
            3'd2: alu_result <= bus.alu_in1 + bus.alu_in2;
            3'd3: alu_result <= bus.alu_in1 - bus.alu_in2;
            3'd4: alu_result <= bus.alu_in1 << bus.alu_in2[3:0];
            3'd5: alu_result <= bus.alu_in1 >> bus.alu_in2[3:0];
            3'd6: alu_result <= 16'($signed(bus.alu_in1) >>> bus.alu_in2[3:0]);
            default: alu_result <= {15'd0, bus.alu_in1 < bus.alu_in2};
        endcase
    end

    function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] rs,
                                          input logic [15:0] rt, input logic [7:0] imm);
        logic        [15:0] s;
        logic        [15:0] z;
        logic signed [15:0] srs;
        s   = {{8{imm[7]}}, imm};
        z   = {8'h00, imm};
        srs = rs;
        case (op)
            4'd0:  return rs & rt;
            4'd1:  return rs | rt;
            4'd2:  return rs + rt;
            4'd3:  return rs - rt;
            4'd4:  return rs << rt[3:0];
            4'd5:  return rs >> rt[3:0];
            4'd6:  return 16'(srs >>> rt[3:0]);
            4'd7:  return (rs < rt) ? 16'd1 : 16'd0;
            4'd8:  return rs + s;
            4'd9:  return rs & z;
            4'd10: return rs | z;
            4'd11: return (rs < s) ? 16'd1 : 16'd0;
            4'd12: return rs << imm[3:0];
            4'd13: return rs >> imm[3:0];
            4'd14: return 16'(srs >>> imm[3:0]);
            default: return 16'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (rr_rand) bus.res_ready = 1'($urandom_range(0, 1));
        else         bus.res_ready = rr_force;
    end

    // Monitor: compares the ALU output against the scoreboard head whenever a result is presented.
    always @(negedge clock) begin
        #1;
        if (!reset) begin
            chk("illegal_op", {31'd0, bus.illegal_op}, {31'd0, ill_flag});
            ill_flag = 0;
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, !(bus.res_valid && !bus.res_ready)});
            if (bus.res_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_result: res_valid=1 dest=%0d with nothing expected at %0t",
                             bus.res_dest, $time);
                end else begin
                    chk("result", {16'd0, alu_result}, {16'd0, exp_q[0].res});
                    chk("res_dest", {29'd0, bus.res_dest}, {29'd0, exp_q[0].dest});
                    if (bus.res_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [15:0] rs, input logic [15:0] rt,
                        input logic [7:0] imm, input logic [2:0] dest);
        bit   ok = 0;
        int   n  = 0;
        exp_t e;
        @(negedge clock);
        #2;
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_rs_val = rs;
        bus.in_rt_val = rt;
        bus.in_imm    = imm;
        bus.in_dest   = dest;
        forever begin
            ok = bus.in_ready;
            @(posedge clock);
            if (ok) break;
            n++;
            if (n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
                break;
            end
            @(negedge clock);
            #2;
        end
        if (ok) begin
            if (op == 4'd15) ill_flag = 1;
            else begin
                e.res  = model(op, rs, rt, imm);
                e.dest = dest;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic directed(input string name, input logic [3:0] op, input logic [15:0] rs,
                            input logic [7:0] imm, input logic [15:0] exp_in2,
                            input logic [15:0] exp_res);
        send(op, rs, 16'h0000, imm, 3'd5);
        @(negedge clock);
        bus.in_valid = 1'b0;
        #3;
        chk({name, "_in2"}, {16'd0, bus.alu_in2}, {16'd0, exp_in2});
        @(negedge clock);
        #3;
        chk({name, "_res"}, {16'd0, alu_result}, {16'd0, exp_res});
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 4'd0;
        bus.in_rs_val = 16'd0;
        bus.in_rt_val = 16'd0;
        bus.in_imm    = 8'd0;
        bus.in_dest   = 3'd0;
        bus.res_ready = 1'b1;
        repeat (2) @(negedge clock);
        #3;
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_dest", {29'd0, bus.res_dest}, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal_op}, 32'd0);
        chk("rst_alu_in1", {16'd0, bus.alu_in1}, 32'd0);
        chk("rst_alu_in2", {16'd0, bus.alu_in2}, 32'd0);
        chk("rst_alu_ctrl", {29'd0, bus.alu_control}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Back-to-back register ops
        send(4'd2, 16'h0003, 16'h0004, 8'h00, 3'd1);
        send(4'd3, 16'h0010, 16'h0001, 8'h00, 3'd2);
        @(negedge clock);
        bus.in_valid = 1'b0;
        #3;
        chk("b2b_res0", {16'd0, alu_result}, 32'h0007);
        chk("b2b_dest0", {29'd0, bus.res_dest}, 32'd1);
        chk("b2b_valid0", {31'd0, bus.res_valid}, 32'd1);
        @(negedge clock);
        #3;
        chk("b2b_res1", {16'd0, alu_result}, 32'h000F);
        chk("b2b_dest1", {29'd0, bus.res_dest}, 32'd2);
        chk("b2b_valid1", {31'd0, bus.res_valid}, 32'd1);
        @(negedge clock);
        #3;
        chk("b2b_valid2", {31'd0, bus.res_valid}, 32'd0);

        // Immediate forms
        directed("addi", 4'd8,  16'h0005, 8'hFF, 16'hFFFF, 16'h0004);
        directed("andi", 4'd9,  16'h1234, 8'hFF, 16'h00FF, 16'h0034);
        directed("srai", 4'd14, 16'h8000, 8'h04, 16'h0004, 16'hF800);
        directed("slti", 4'd11, 16'h0001, 8'h80, 16'hFF80, 16'h0001);

        // Stall for 3 cycles while A is valid
        send(4'd2, 16'h0001, 16'h0001, 8'h00, 3'd3);
        send(4'd2, 16'h0002, 16'h0002, 8'h00, 3'd4);
        rr_force = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            #4;
            chk("stall_res", {16'd0, alu_result}, 32'h0002);
            chk("stall_dest", {29'd0, bus.res_dest}, 32'd3);
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        rr_force = 1;
        @(negedge clock);
        #4;
        chk("rel_res_a", {16'd0, alu_result}, 32'h0002);
        chk("rel_dest_a", {29'd0, bus.res_dest}, 32'd3);
        @(negedge clock);
        #4;
        chk("rel_res_b", {16'd0, alu_result}, 32'h0004);
        chk("rel_dest_b", {29'd0, bus.res_dest}, 32'd4);
        @(negedge clock);
        #4;
        chk("rel_done", {31'd0, bus.res_valid}, 32'd0);

        // Illegal opcode followed by a legal op
        send(4'd15, 16'h1111, 16'h2222, 8'h33, 3'd6);
        @(negedge clock);
        bus.in_valid = 1'b0;
        #3;
        chk("ill_pulse", {31'd0, bus.illegal_op}, 32'd1);
        @(negedge clock);
        #3;
        chk("ill_gone", {31'd0, bus.illegal_op}, 32'd0);
        chk("ill_no_res", {31'd0, bus.res_valid}, 32'd0);
        directed("after_ill", 4'd10, 16'h1200, 8'h34, 16'h0034, 16'h1234);

        // Randomised stream with random backpressure
        rr_rand = 1;
        for (int i = 0; i < 400; i++) begin
            send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 8'($urandom),
                 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clock);
                bus.in_valid = 1'b0;
            end
        end
        rr_rand  = 0;
        rr_force = 1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        #3;
        chk("drain", exp_q.size(), 32'd0);

        // Asynchronous reset mid-stream
        send(4'd3, 16'h0009, 16'h0002, 8'h00, 3'd7);
        send(4'd15, 16'h0000, 16'h0000, 8'h00, 3'd0);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("arst_illegal", {31'd0, bus.illegal_op}, 32'd0);
        chk("arst_alu_ctrl", {29'd0, bus.alu_control}, 32'd0);
        exp_q.delete();
        ill_flag     = 0;
        bus.in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #2;
        chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        directed("post_rst", 4'd0, 16'h00F0, 8'h00, 16'h0000, 16'h0000);
        repeat (3) @(negedge clock);
        #3;
        chk("final_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
